// File: rtl/ccsds123_stim_gen.sv
// ccsds123_stim_gen
//   AXI4-Stream sample source and result monitor for the CCSDS-123 compressor.
//   Emits frames (1..255, 0 means 1) of NX*NY*NZ samples in BIP order, LANES
//   samples per beat, with one of four data patterns and LFSR-driven bubbles.
//   tready is fully honoured. In parallel it counts compressor output strobes
//   and flags when frames*N of them have arrived.
//
// Ports
//   clk, aresetn          : clock, asynchronous active-low reset
//   start                 : one-cycle start pulse (ignored while running)
//   mode                  : 0 ramp, 1 descending, 2 LFSR random, 3 all-ones
//   bubble_thresh         : bubble probability thresh/256, 0 disables bubbles
//   frames                : number of frames to send, 0 treated as 1
//   m_axis_tdata/tvalid/tlast/tready : sample stream, lane 0 in the LSBs
//   res_valid             : compressor output word strobe
//   busy, done            : source active / all beats accepted
//   res_count, res_done   : saturating strobe count since start, count reached
//
// D must not exceed 32 (random samples are taken from a 32-bit LFSR).
module ccsds123_stim_gen #(
  parameter int unsigned D         = 16,
  parameter int unsigned NX        = 4,
  parameter int unsigned NY        = 4,
  parameter int unsigned NZ        = 16,
  parameter int unsigned LANES     = 1,
  parameter int unsigned FW        = 8,
  parameter int unsigned CW        = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [7:0]           bubble_thresh,
  input  logic [FW-1:0]        frames,
  output logic [LANES*D-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  input  logic                 res_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        res_count,
  output logic                 res_done
);

  localparam int unsigned N    = NX * NY * NZ;
  localparam int unsigned IW   = $clog2(N + 1);
  localparam logic [31:0] POLY = 32'h80200003;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  state_t               r_state;
  logic [1:0]           r_mode;
  logic [7:0]           r_thresh;
  logic [FW-1:0]        r_frames_eff;
  logic [CW-1:0]        r_expected;
  logic [IW-1:0]        r_idx;
  logic [FW-1:0]        r_frame;
  logic                 r_final;
  logic [31:0]          r_dlfsr;
  logic [31:0]          r_blfsr;
  logic [LANES*D-1:0]   r_tdata;
  logic                 r_tvalid;
  logic                 r_tlast;
  logic                 r_busy;
  logic                 r_done;
  logic [CW-1:0]        r_res_count;
  logic                 r_res_done;

  logic                 w_start;
  logic                 w_accept;
  logic                 w_finish;
  logic                 w_decide;
  logic                 w_bubble;
  logic [1:0]           w_mode;
  logic [7:0]           w_thresh;
  logic [FW-1:0]        w_frames_in;
  logic [FW-1:0]        w_frames_eff;
  logic [IW-1:0]        w_idx;
  logic [FW-1:0]        w_frame;
  logic                 w_last_beat;
  logic                 w_final;
  logic [IW-1:0]        w_next_idx;
  logic [LANES*D-1:0]   w_beat;
  logic [31:0]          w_walk;
  logic [31:0]          w_dlfsr_next;

  assign w_start  = start && (r_state != S_RUN);
  assign w_accept = r_tvalid && m_axis_tready;
  assign w_finish = (r_state == S_RUN) && w_accept && r_final;
  // A decision cycle either presents the next beat or draws a bubble. The
  // start cycle is one as well, so beat 0 can appear right after start.
  assign w_decide = w_start || ((r_state == S_RUN) && (!r_tvalid || w_accept));

  // On the start cycle the registered settings are stale; use the inputs.
  assign w_frames_in  = (frames == '0) ? FW'(1) : frames;
  assign w_mode       = w_start ? mode          : r_mode;
  assign w_thresh     = w_start ? bubble_thresh : r_thresh;
  assign w_frames_eff = w_start ? w_frames_in   : r_frames_eff;
  assign w_idx        = w_start ? '0            : r_idx;
  assign w_frame      = w_start ? '0            : r_frame;

  assign w_bubble    = (r_blfsr[7:0] < w_thresh);
  assign w_last_beat = ((32'(w_idx) + LANES) == N);
  assign w_final     = w_last_beat && ((32'(w_frame) + 32'd1) == 32'(w_frames_eff));
  assign w_next_idx  = w_last_beat ? '0 : IW'(32'(w_idx) + LANES);

  // Lane k takes the data LFSR after k steps; the register advances LANES steps.
  always_comb begin
    w_beat = '0;
    w_walk = r_dlfsr;
    for (int unsigned k = 0; k < LANES; k++) begin
      case (w_mode)
        2'd0:    w_beat[k*D +: D] = D'(32'(w_idx) + k);
        2'd1:    w_beat[k*D +: D] = D'(N - 32'd1 - 32'(w_idx) - k);
        2'd2:    w_beat[k*D +: D] = w_walk[D-1:0];
        default: w_beat[k*D +: D] = '1;
      endcase
      w_walk = lfsr_step(w_walk);
    end
    w_dlfsr_next = w_walk;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_mode       <= '0;
      r_thresh     <= '0;
      r_frames_eff <= '0;
      r_expected   <= '0;
      r_idx        <= '0;
      r_frame      <= '0;
      r_final      <= 1'b0;
      r_dlfsr      <= LFSR_SEED;
      r_blfsr      <= LFSR_SEED;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_res_count  <= '0;
      r_res_done   <= 1'b0;
    end else begin
      if (w_start) begin
        r_state      <= S_RUN;
        r_mode       <= mode;
        r_thresh     <= bubble_thresh;
        r_frames_eff <= w_frames_in;
        r_expected   <= CW'(w_frames_in) * CW'(N);
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_idx        <= '0;
        r_frame      <= '0;
        r_res_count  <= '0;
        r_res_done   <= 1'b0;
      end else if (r_state != S_IDLE) begin
        if (res_valid && (r_res_count != '1))
          r_res_count <= r_res_count + CW'(1);
        if (r_res_count >= r_expected)
          r_res_done <= 1'b1;
      end

      if (w_finish) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end

      if (w_decide) begin
        r_blfsr <= lfsr_step(r_blfsr);
        if (w_finish || w_bubble) begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end else begin
          r_tvalid <= 1'b1;
          r_tdata  <= w_beat;
          r_tlast  <= w_last_beat;
          r_final  <= w_final;
          r_dlfsr  <= w_dlfsr_next;
          r_idx    <= w_next_idx;
          if (w_last_beat)
            r_frame <= w_frame + FW'(1);
        end
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign done          = r_done;
  assign res_count     = r_res_count;
  assign res_done      = r_res_done;

endmodule

// File: tb/tb_ccsds123_stim_gen.sv
// Testbench for ccsds123_stim_gen: two instances (LANES=1 and LANES=4, both
// N=1024) checked against a sample-index based reference model.
module tb_ccsds123_stim_gen;

  localparam int N = 1024;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;

  logic        start1, tvalid1, tlast1, tready1, res_valid1, busy1, done1, res_done1;
  logic [1:0]  mode1;
  logic [7:0]  thr1, frames1;
  logic [15:0] tdata1;
  logic [31:0] res_count1;

  logic        start4, tvalid4, tlast4, tready4, res_valid4, busy4, done4, res_done4;
  logic [1:0]  mode4;
  logic [7:0]  thr4, frames4;
  logic [63:0] tdata4;
  logic [11:0] res_count4;

  ccsds123_stim_gen #(.D(16), .NX(8), .NY(8), .NZ(16), .LANES(1), .FW(8), .CW(32),
                      .LFSR_SEED(SEED)) u1 (
    .clk(clk), .aresetn(aresetn), .start(start1), .mode(mode1),
    .bubble_thresh(thr1), .frames(frames1), .m_axis_tdata(tdata1),
    .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1), .m_axis_tready(tready1),
    .res_valid(res_valid1), .busy(busy1), .done(done1),
    .res_count(res_count1), .res_done(res_done1));

  ccsds123_stim_gen #(.D(16), .NX(8), .NY(8), .NZ(16), .LANES(4), .FW(8), .CW(12),
                      .LFSR_SEED(SEED)) u4 (
    .clk(clk), .aresetn(aresetn), .start(start4), .mode(mode4),
    .bubble_thresh(thr4), .frames(frames4), .m_axis_tdata(tdata4),
    .m_axis_tvalid(tvalid4), .m_axis_tlast(tlast4), .m_axis_tready(tready4),
    .res_valid(res_valid4), .busy(busy4), .done(done4),
    .res_count(res_count4), .res_done(res_done4));

  int checks = 0;
  int errors = 0;

  // Selects which instance the stream collector observes.
  bit sel = 1'b0;
  logic        m_tvalid, m_tlast, m_done, m_busy;
  logic [63:0] m_tdata;
  assign m_tvalid = sel ? tvalid4 : tvalid1;
  assign m_tlast  = sel ? tlast4  : tlast1;
  assign m_done   = sel ? done4   : done1;
  assign m_busy   = sel ? busy4   : busy1;
  assign m_tdata  = sel ? tdata4  : {48'd0, tdata1};

  logic [63:0] q_data[$];
  bit          q_last[$];
  int first_valid, bubbles, stall_err, done_cycle, last_accept;

  logic [31:0] rnd_seq [N];

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  // Expected beat b of a run: lane k carries global sample b*lanes+k,
  // whose in-frame index restarts every N samples.
  function automatic logic [63:0] exp_beat(input int mode, input int lanes, input int b);
    logic [63:0] r;
    logic [15:0] s;
    int g;
    int i;
    r = '0;
    for (int k = 0; k < lanes; k++) begin
      g = b * lanes + k;
      i = g % N;
      case (mode)
        0:       s = 16'(i);
        1:       s = 16'(N - 1 - i);
        2:       s = rnd_seq[g % N][15:0];
        default: s = 16'hFFFF;
      endcase
      r = r | (64'(s) << (16 * k));
    end
    return r;
  endfunction

  task automatic do_reset();
    aresetn = 1'b0;
    start1 = 0; mode1 = 0; thr1 = 0; frames1 = 0; tready1 = 0; res_valid1 = 0;
    start4 = 0; mode4 = 0; thr4 = 0; frames4 = 0; tready4 = 0; res_valid4 = 0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_run(input bit s, input logic [1:0] m, input logic [7:0] th,
                           input logic [7:0] fr);
    sel = s;
    @(negedge clk);
    if (!s) begin start1 = 1; mode1 = m; thr1 = th; frames1 = fr; end
    else    begin start4 = 1; mode4 = m; thr4 = th; frames4 = fr; end
    @(posedge clk);
    #1;
    start1 = 0;
    start4 = 0;
  endtask

  // Drives tready and records accepted beats until done, max_beats, or budget.
  task automatic collect(input bit rnd, input int budget, input int max_beats,
                         input int restart_at);
    bit rdy;
    bit prev_hold;
    logic [63:0] prev_d;
    bit prev_l;
    q_data.delete(); q_last.delete();
    first_valid = -1; bubbles = 0; stall_err = 0; done_cycle = -1; last_accept = -1;
    prev_hold = 0; prev_d = '0; prev_l = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == restart_at) begin start1 = 1; mode1 = 2'd3; end
      else if (c == restart_at + 1) start1 = 0;
      if (m_done) begin done_cycle = c; break; end
      if (max_beats > 0 && q_data.size() >= max_beats) break;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tready1 = rdy;
      tready4 = rdy;
      if (first_valid < 0 && m_tvalid) first_valid = c;
      if (prev_hold && (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l)) stall_err++;
      if (!m_tvalid) bubbles++;
      if (m_tvalid && rdy) begin
        q_data.push_back(m_tdata);
        q_last.push_back(m_tlast);
        last_accept = c;
        prev_hold = 0;
      end else begin
        prev_hold = m_tvalid;
        prev_d = m_tdata;
        prev_l = m_tlast;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({tvalid1, tlast1, busy1, done1, res_done1} !== 5'b0) begin errors++;
      $display("FAIL reset_flags1: got %b expected 00000", {tvalid1, tlast1, busy1, done1, res_done1}); end
    checks++; if (tdata1 !== 16'h0) begin errors++;
      $display("FAIL reset_tdata1: got %h expected 0", tdata1); end
    checks++; if (res_count1 !== 32'd0) begin errors++;
      $display("FAIL reset_count1: got %0d expected 0", res_count1); end
    checks++; if ({tvalid4, tlast4, busy4, done4, res_done4} !== 5'b0 || tdata4 !== 64'd0
                  || res_count4 !== 12'd0) begin errors++;
      $display("FAIL reset_u4: flags %b data %h count %0d expected all 0",
               {tvalid4, tlast4, busy4, done4, res_done4}, tdata4, res_count4); end
  endtask

  task automatic test_ramp();
    int mm;
    int nl;
    do_reset();
    start_run(0, 2'd0, 8'd0, 8'd1);
    collect(0, 3000, 0, -1);
    checks++; if (first_valid !== 0) begin errors++;
      $display("FAIL ramp_latency: got first valid at %0d expected 0", first_valid); end
    checks++; if (q_data.size() !== N) begin errors++;
      $display("FAIL ramp_count: got %0d beats expected %0d", q_data.size(), N); end
    mm = 0; nl = 0;
    foreach (q_data[b]) begin
      if (q_data[b] !== exp_beat(0, 1, b)) mm++;
      if (q_last[b] !== (b == N - 1)) nl++;
    end
    checks++; if (mm !== 0) begin errors++;
      $display("FAIL ramp_data: got %0d mismatching beats expected 0", mm); end
    checks++; if (nl !== 0) begin errors++;
      $display("FAIL ramp_tlast: got %0d misplaced tlast expected 0", nl); end
    checks++; if (bubbles !== 0 || last_accept !== N - 1) begin errors++;
      $display("FAIL ramp_throughput: got %0d bubbles, last accept %0d expected 0, %0d",
               bubbles, last_accept, N - 1); end
    checks++; if (done_cycle !== last_accept + 1) begin errors++;
      $display("FAIL ramp_done: got done at %0d expected %0d", done_cycle, last_accept + 1); end
    checks++; if (m_busy !== 1'b0) begin errors++;
      $display("FAIL ramp_busy: got %b expected 0", m_busy); end
  endtask

  task automatic test_stall();
    int mm;
    int nl;
    start_run(0, 2'd0, 8'd0, 8'd1);
    collect(1, 6000, 0, 100);
    checks++; if (q_data.size() !== N) begin errors++;
      $display("FAIL stall_count: got %0d beats expected %0d", q_data.size(), N); end
    mm = 0; nl = 0;
    foreach (q_data[b]) begin
      if (q_data[b] !== exp_beat(0, 1, b)) mm++;
      if (q_last[b] !== (b == N - 1)) nl++;
    end
    checks++; if (mm !== 0 || nl !== 0) begin errors++;
      $display("FAIL stall_data: got %0d data / %0d tlast mismatches expected 0", mm, nl); end
    checks++; if (stall_err !== 0) begin errors++;
      $display("FAIL stall_hold: got %0d unstable held beats expected 0", stall_err); end
    checks++; if (done_cycle !== last_accept + 1) begin errors++;
      $display("FAIL stall_done: got done at %0d expected %0d", done_cycle, last_accept + 1); end
  endtask

  task automatic test_lanes4();
    int mm;
    int nl;
    start_run(1, 2'd1, 8'd0, 8'd1);
    collect(0, 1000, 0, -1);
    checks++; if (q_data.size() !== N / 4) begin errors++;
      $display("FAIL lanes4_count: got %0d beats expected %0d", q_data.size(), N / 4); end
    checks++; if (q_data.size() == 0 || q_data[0] !== 64'h03FC_03FD_03FE_03FF) begin errors++;
      $display("FAIL lanes4_beat0: got %h expected 03fc03fd03fe03ff",
               (q_data.size() == 0) ? 64'd0 : q_data[0]); end
    mm = 0; nl = 0;
    foreach (q_data[b]) begin
      if (q_data[b] !== exp_beat(1, 4, b)) mm++;
      if (q_last[b] !== (b == N / 4 - 1)) nl++;
    end
    checks++; if (mm !== 0 || nl !== 0) begin errors++;
      $display("FAIL lanes4_data: got %0d data / %0d tlast mismatches expected 0", mm, nl); end
    sel = 0;
  endtask

  task automatic test_bubbles();
    int mm;
    int nl;
    start_run(0, 2'd0, 8'd128, 8'd3);
    collect(0, 12000, 0, -1);
    checks++; if (q_data.size() !== 3 * N) begin errors++;
      $display("FAIL bubble_count: got %0d beats expected %0d", q_data.size(), 3 * N); end
    mm = 0; nl = 0;
    foreach (q_data[b]) begin
      if (q_data[b] !== exp_beat(0, 1, b)) mm++;
      if (q_last[b] !== ((b + 1) % N == 0)) nl++;
    end
    checks++; if (mm !== 0 || nl !== 0) begin errors++;
      $display("FAIL bubble_data: got %0d data / %0d tlast mismatches expected 0", mm, nl); end
    checks++; if (bubbles == 0) begin errors++;
      $display("FAIL bubble_present: got %0d bubble cycles expected >0", bubbles); end
    checks++; if (done_cycle !== last_accept + 1) begin errors++;
      $display("FAIL bubble_done: got done at %0d expected %0d", done_cycle, last_accept + 1); end
  endtask

  task automatic test_reset_midrun();
    int mm;
    do_reset();
    start_run(0, 2'd2, 8'd0, 8'd1);
    collect(0, 2000, 500, -1);
    mm = 0;
    foreach (q_data[b]) if (q_data[b] !== exp_beat(2, 1, b)) mm++;
    checks++; if (q_data.size() !== 500 || mm !== 0) begin errors++;
      $display("FAIL midrun_partial: got %0d beats, %0d mismatches expected 500, 0",
               q_data.size(), mm); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if ({tvalid1, tlast1, busy1, done1} !== 4'b0 || tdata1 !== 16'h0) begin errors++;
      $display("FAIL midrun_async: flags %b data %h expected 0000 0",
               {tvalid1, tlast1, busy1, done1}, tdata1); end
    @(negedge clk);
    aresetn = 1'b1;
    start_run(0, 2'd2, 8'd0, 8'd1);
    collect(0, 3000, 0, -1);
    mm = 0;
    foreach (q_data[b]) if (q_data[b] !== exp_beat(2, 1, b)) mm++;
    checks++; if (q_data.size() !== N || mm !== 0) begin errors++;
      $display("FAIL midrun_rerun: got %0d beats, %0d mismatches expected %0d, 0",
               q_data.size(), mm, N); end
    checks++; if (done_cycle !== last_accept + 1) begin errors++;
      $display("FAIL midrun_done: got done at %0d expected %0d", done_cycle, last_accept + 1); end
  endtask

  task automatic test_res();
    int pulses;
    do_reset();
    tready1 = 1'b1;
    @(negedge clk);
    start1 = 1; mode1 = 2'd0; thr1 = 8'd0; frames1 = 8'd1; res_valid1 = 1;
    @(posedge clk);
    #1;
    start1 = 0; res_valid1 = 0;
    pulses = 0;
    for (int c = 0; c < 5000 && pulses < 1023; c++) begin
      @(negedge clk);
      res_valid1 = 1'($urandom_range(0, 1));
      if (res_valid1) pulses++;
    end
    @(negedge clk);
    res_valid1 = 0;
    checks++; if (res_count1 !== 32'd1023 || res_done1 !== 1'b0) begin errors++;
      $display("FAIL res_1023: got count %0d done %b expected 1023 0", res_count1, res_done1); end
    res_valid1 = 1;
    @(posedge clk);
    #1;
    res_valid1 = 0;
    checks++; if (res_count1 !== 32'd1024) begin errors++;
      $display("FAIL res_1024: got count %0d expected 1024", res_count1); end
    @(posedge clk);
    #1;
    checks++; if (res_done1 !== 1'b1) begin errors++;
      $display("FAIL res_done: got %b expected 1", res_done1); end
    @(negedge clk);
    start1 = 1; res_valid1 = 1;
    @(posedge clk);
    #1;
    start1 = 0; res_valid1 = 0;
    checks++; if (res_count1 !== 32'd0 || res_done1 !== 1'b0) begin errors++;
      $display("FAIL res_clear: got count %0d done %b expected 0 0", res_count1, res_done1); end
  endtask

  task automatic test_res_saturate();
    do_reset();
    start_run(1, 2'd0, 8'd0, 8'd1);
    tready4 = 1'b1;
    res_valid4 = 1'b1;
    repeat (4200) @(negedge clk);
    res_valid4 = 1'b0;
    @(negedge clk);
    checks++; if (res_count4 !== 12'hFFF || res_done4 !== 1'b1) begin errors++;
      $display("FAIL res_saturate: got count %0d done %b expected 4095 1", res_count4, res_done4); end
    sel = 0;
  endtask

  initial begin
    rnd_seq[0] = SEED;
    for (int j = 1; j < N; j++) rnd_seq[j] = lstep(rnd_seq[j - 1]);
    test_reset();
    test_ramp();
    test_stall();
    test_lanes4();
    test_bubbles();
    test_reset_midrun();
    test_res();
    test_res_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
